// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, a write-back port with
// same-cycle bypass, an immediate override on port 2 and a pending-write scoreboard.
module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int IMM_W    = 4,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_read_add1,
    input  logic [ADDR_W-1:0] i_read_add2,
    input  logic              i_imm_sel,
    input  logic [IMM_W-1:0]  i_imm,
    input  logic              i_write_en,
    input  logic [ADDR_W-1:0] i_write_add,
    input  logic [DATA_W-1:0] i_write_data,
    input  logic              i_issue_en,
    input  logic [ADDR_W-1:0] i_issue_add,
    output logic [DATA_W-1:0] o_read_data1,
    output logic [DATA_W-1:0] o_read_data2,
    output logic              o_busy1,
    output logic              o_busy2,
    output logic [ADDR_W:0]   o_pending_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]  pending_reg;
    logic [DEPTH-1:0]  pending_next;
    logic [ADDR_W:0]   cnt_reg;
    logic [ADDR_W:0]   cnt_next;

    logic write_ok;
    logic issue_ok;
    logic cnt_inc;
    logic cnt_dec;
    logic bypass1;
    logic bypass2;
    logic zero1;
    logic zero2;

    // With ZERO_REG set, any access targeting r0 is simply dropped.
    assign write_ok = i_write_en && !((ZERO_REG != 0) && (i_write_add == '0));
    assign issue_ok = i_issue_en && !((ZERO_REG != 0) && (i_issue_add == '0));

    // Issue beats write on the same entry: the newer producer owns the register.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pending
            assign pending_next[gi] =
                (issue_ok && (i_issue_add == ADDR_W'(gi))) ? 1'b1 :
                (write_ok && (i_write_add == ADDR_W'(gi))) ? 1'b0 :
                pending_reg[gi];
        end
    endgenerate

    assign cnt_inc  = issue_ok && !pending_reg[i_issue_add];
    assign cnt_dec  = write_ok && pending_reg[i_write_add] &&
                      !(issue_ok && (i_issue_add == i_write_add));
    assign cnt_next = cnt_reg + (ADDR_W + 1)'(cnt_inc) - (ADDR_W + 1)'(cnt_dec);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
            pending_reg <= '0;
            cnt_reg     <= '0;
        end else begin
            if (write_ok) begin
                regs_reg[i_write_add] <= i_write_data;
            end
            pending_reg <= pending_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign bypass1 = i_write_en && (i_write_add == i_read_add1);
    assign bypass2 = i_write_en && (i_write_add == i_read_add2);
    assign zero1   = (ZERO_REG != 0) && (i_read_add1 == '0);
    assign zero2   = (ZERO_REG != 0) && (i_read_add2 == '0);

    always_comb begin
        o_read_data1 = regs_reg[i_read_add1];
        o_busy1      = pending_reg[i_read_add1] && !bypass1;
        if (bypass1) begin
            o_read_data1 = i_write_data;
        end
        if (zero1) begin
            o_read_data1 = '0;
            o_busy1      = 1'b0;
        end
        if (reset) begin
            o_read_data1 = '0;
            o_busy1      = 1'b0;
        end
    end

    always_comb begin
        o_read_data2 = regs_reg[i_read_add2];
        o_busy2      = pending_reg[i_read_add2] && !bypass2;
        if (bypass2) begin
            o_read_data2 = i_write_data;
        end
        if (zero2) begin
            o_read_data2 = '0;
            o_busy2      = 1'b0;
        end
        if (i_imm_sel) begin
            o_read_data2 = DATA_W'(i_imm);
            o_busy2      = 1'b0;
        end
        if (reset) begin
            o_read_data2 = '0;
            o_busy2      = 1'b0;
        end
    end

    assign o_pending_cnt = cnt_reg;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one instance without and one with a hardwired r0,
// both driven by the same stimulus.
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ra1, ra2, imm, wa, ia;
    logic        isel, we, ie;
    logic [15:0] wd;
    logic [15:0] d1_a, d2_a, d1_z, d2_z;
    logic        b1_a, b2_a, b1_z, b2_z;
    logic [4:0]  cnt_a, cnt_z;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(16), .ADDR_W(4), .IMM_W(4), .ZERO_REG(0)) dut_a (
        .clk(clk), .reset(reset),
        .i_read_add1(ra1), .i_read_add2(ra2), .i_imm_sel(isel), .i_imm(imm),
        .i_write_en(we), .i_write_add(wa), .i_write_data(wd),
        .i_issue_en(ie), .i_issue_add(ia),
        .o_read_data1(d1_a), .o_read_data2(d2_a), .o_busy1(b1_a), .o_busy2(b2_a),
        .o_pending_cnt(cnt_a)
    );

    reg_file_sb #(.DATA_W(16), .ADDR_W(4), .IMM_W(4), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset),
        .i_read_add1(ra1), .i_read_add2(ra2), .i_imm_sel(isel), .i_imm(imm),
        .i_write_en(we), .i_write_add(wa), .i_write_data(wd),
        .i_issue_en(ie), .i_issue_add(ia),
        .o_read_data1(d1_z), .o_read_data2(d2_z), .o_busy1(b1_z), .o_busy2(b2_z),
        .o_pending_cnt(cnt_z)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  ra1, ra2;
        logic        isel;
        logic [3:0]  imm;
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        ie;
        logic [3:0]  ia;
        logic [15:0] e_d1, e_d2;
        logic        e_b1, e_b2;
        logic [4:0]  e_cnt;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(logic rst_v, logic [3:0] ra1_v, logic [3:0] ra2_v,
                                logic isel_v, logic [3:0] imm_v,
                                logic we_v, logic [3:0] wa_v, logic [15:0] wd_v,
                                logic ie_v, logic [3:0] ia_v,
                                logic [15:0] e_d1_v, logic [15:0] e_d2_v,
                                logic e_b1_v, logic e_b2_v, logic [4:0] e_cnt_v);
        vec_t v;
        v.rst = rst_v; v.ra1 = ra1_v; v.ra2 = ra2_v; v.isel = isel_v; v.imm = imm_v;
        v.we = we_v; v.wa = wa_v; v.wd = wd_v; v.ie = ie_v; v.ia = ia_v;
        v.e_d1 = e_d1_v; v.e_d2 = e_d2_v; v.e_b1 = e_b1_v; v.e_b2 = e_b2_v;
        v.e_cnt = e_cnt_v;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; ra1 = '0; ra2 = '0; isel = 1'b0; imm = '0;
        we = 1'b0; wa = '0; wd = '0; ie = 1'b0; ia = '0;
    endtask

    initial begin
        // rst ra1 ra2 isel imm we wa wd ie ia | d1 d2 b1 b2 cnt
        vecs[0]  = mk(0, 5, 0, 0, 0, 1, 5, 16'hBEEF, 0, 0, 16'hBEEF, 16'h0000, 0, 0, 0);
        vecs[1]  = mk(0, 5, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'hBEEF, 16'h0000, 0, 0, 0);
        vecs[2]  = mk(1, 5, 5, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[3]  = mk(0, 5, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[4]  = mk(0, 3, 0, 0, 0, 1, 3, 16'h1234, 0, 0, 16'h1234, 16'h0000, 0, 0, 0);
        vecs[5]  = mk(0, 3, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h1234, 16'h0000, 0, 0, 0);
        vecs[6]  = mk(0, 7, 0, 0, 0, 0, 0, 16'h0000, 1, 7, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[7]  = mk(0, 7, 7, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 1, 1);
        vecs[8]  = mk(0, 7, 3, 0, 0, 1, 7, 16'h00AA, 0, 0, 16'h00AA, 16'h1234, 0, 0, 1);
        vecs[9]  = mk(0, 7, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h00AA, 16'h0000, 0, 0, 0);
        vecs[10] = mk(0, 2, 0, 0, 0, 0, 0, 16'h0000, 1, 2, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[11] = mk(0, 2, 0, 0, 0, 1, 2, 16'h5555, 1, 2, 16'h5555, 16'h0000, 0, 0, 1);
        vecs[12] = mk(0, 2, 2, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h5555, 16'h5555, 1, 1, 1);
        vecs[13] = mk(0, 2, 2, 1, 4'hC, 0, 0, 16'h0000, 0, 0, 16'h5555, 16'h000C, 1, 0, 1);
        vecs[14] = mk(0, 9, 0, 0, 0, 0, 0, 16'h0000, 1, 2, 16'h0000, 16'h0000, 0, 0, 1);
        vecs[15] = mk(0, 2, 0, 0, 0, 1, 9, 16'h0909, 0, 0, 16'h5555, 16'h0000, 1, 0, 1);
        vecs[16] = mk(0, 2, 4, 0, 0, 1, 2, 16'h6666, 1, 4, 16'h6666, 16'h0000, 0, 0, 1);
        vecs[17] = mk(0, 2, 4, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h6666, 16'h0000, 0, 1, 1);
        vecs[18] = mk(1, 2, 4, 0, 0, 0, 0, 16'h0000, 1, 5, 16'h0000, 16'h0000, 0, 0, 1);
        vecs[19] = mk(0, 2, 4, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);

        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Reset state across every address on both ports
        for (int a = 0; a < 16; a++) begin
            idle_inputs();
            ra1 = 4'(a);
            ra2 = 4'(15 - a);
            #1;
            chk("rst_d1", 32'(d1_a), 32'h0);
            chk("rst_d2", 32'(d2_a), 32'h0);
            chk("rst_busy", 32'({b1_a, b2_a}), 32'h0);
            chk("rst_cnt", 32'(cnt_a), 32'h0);
            $display("reset read a=%0d d1=%h d2=%h cnt=%0d", a, d1_a, d2_a, cnt_a);
            @(negedge clk);
        end

        for (int i = 0; i < 20; i++) begin
            reset = vecs[i].rst; ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
            isel = vecs[i].isel; imm = vecs[i].imm;
            we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
            ie = vecs[i].ie; ia = vecs[i].ia;
            #1;
            chk($sformatf("v%0d_d1", i), 32'(d1_a), 32'(vecs[i].e_d1));
            chk($sformatf("v%0d_d2", i), 32'(d2_a), 32'(vecs[i].e_d2));
            chk($sformatf("v%0d_b1", i), 32'(b1_a), 32'(vecs[i].e_b1));
            chk($sformatf("v%0d_b2", i), 32'(b2_a), 32'(vecs[i].e_b2));
            chk($sformatf("v%0d_cnt", i), 32'(cnt_a), 32'(vecs[i].e_cnt));
            $display("vec %0d d1=%h d2=%h b1=%b b2=%b cnt=%0d", i, d1_a, d2_a, b1_a, b2_a, cnt_a);
            @(negedge clk);
        end

        // r0 write+issue: hardwired on dut_z, ordinary register on dut_a
        idle_inputs();
        we = 1'b1; wa = 4'd0; wd = 16'hFFFF; ie = 1'b1; ia = 4'd0; ra1 = 4'd0;
        #1;
        chk("z0_d1_z", 32'(d1_z), 32'h0);
        chk("z0_b1_z", 32'(b1_z), 32'h0);
        chk("z0_d1_a", 32'(d1_a), 32'hFFFF);
        $display("r0 write+issue d1_z=%h d1_a=%h", d1_z, d1_a);
        @(negedge clk);
        idle_inputs();
        ra1 = 4'd0;
        #1;
        chk("z1_d1_z", 32'(d1_z), 32'h0);
        chk("z1_b1_z", 32'(b1_z), 32'h0);
        chk("z1_cnt_z", 32'(cnt_z), 32'h0);
        chk("z1_d1_a", 32'(d1_a), 32'hFFFF);
        chk("z1_b1_a", 32'(b1_a), 32'h1);
        chk("z1_cnt_a", 32'(cnt_a), 32'h1);
        $display("r0 read d1_z=%h b1_z=%b cnt_z=%0d cnt_a=%0d", d1_z, b1_z, cnt_z, cnt_a);

        for (int a = 1; a < 16; a++) begin
            @(negedge clk);
            idle_inputs();
            ie = 1'b1;
            ia = 4'(a);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk("full_cnt_z", 32'(cnt_z), 32'd15);
        chk("full_cnt_a", 32'(cnt_a), 32'd16);
        $display("all issued cnt_z=%0d cnt_a=%0d", cnt_z, cnt_a);

        // Re-issue at full occupancy must not wrap
        ie = 1'b1; ia = 4'd5;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("reissue_cnt_a", 32'(cnt_a), 32'd16);
        chk("reissue_cnt_z", 32'(cnt_z), 32'd15);
        $display("reissue cnt_z=%0d cnt_a=%0d", cnt_z, cnt_a);

        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            idle_inputs();
            we = 1'b1;
            wa = 4'(a);
            wd = 16'(16'h1000 + a);
        end
        @(negedge clk);
        idle_inputs();
        ra1 = 4'd11;
        ra2 = 4'd0;
        #1;
        chk("drain_cnt_a", 32'(cnt_a), 32'd0);
        chk("drain_cnt_z", 32'(cnt_z), 32'd0);
        chk("drain_d1_a", 32'(d1_a), 32'h100B);
        chk("drain_d2_z", 32'(d2_z), 32'h0);
        chk("drain_d2_a", 32'(d2_a), 32'h1000);
        $display("drained cnt_z=%0d cnt_a=%0d d1_a=%h d2_a=%h", cnt_z, cnt_a, d1_a, d2_a);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
